// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, byte-lane stores, returns the full aligned 32-bit word.
// Latency: the response strobe is sampled WAIT_CYCLES+1 clocks after the accept edge; the strobe lasts one cycle.
// Backpressure: req_ready is low from accept through the response cycle; the response itself cannot be stalled.
// Optional feature macro MISALIGN_ERR_EN: reject misaligned/reserved accesses with resp_err instead of ignoring low address bits.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               enter_resp;

  // Storage is deliberately not reset.
  logic [31:0]        mem [2**ADDR_W];

  // Operation fields: straight from the request bus when entering RESP
  // directly from IDLE (zero wait states), otherwise from the latched copy.
  logic               op_we;
  logic [1:0]         op_size;
  logic [ADDR_W+1:0]  op_addr;
  logic [31:0]        op_wdata;
  logic [ADDR_W-1:0]  op_idx;
  logic [3:0]         op_be;
  logic [31:0]        op_wd;
  logic [31:0]        op_old;
  logic [31:0]        op_merged;
  logic               op_err;

  // Only the word-index bits of the address matter; higher bits alias.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Select operation source and build lane enables / merged word.
  always_comb begin
    op_we    = we_q;
    op_size  = size_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      op_we    = req_we;
      op_size  = req_size;
      op_addr  = req_addr[ADDR_W+1:0];
      op_wdata = req_wdata;
    end
    op_idx = op_addr[ADDR_W+1:2];
    op_old = mem[op_idx];
    case (op_size)
      2'b10: begin
        op_be = 4'b0001 << op_addr[1:0];
        op_wd = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        op_be = op_addr[1] ? 4'b1100 : 4'b0011;
        op_wd = {2{op_wdata[15:0]}};
      end
      default: begin
        op_be = 4'b1111;
        op_wd = op_wdata;
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      op_merged[8*k +: 8] = op_be[k] ? op_wd[8*k +: 8] : op_old[8*k +: 8];
    end
`ifdef MISALIGN_ERR_EN
    op_err = (op_size == 2'b11) ||
             ((op_size == 2'b00) && (op_addr[1:0] != 2'b00)) ||
             ((op_size == 2'b01) && op_addr[0]);
`else
    op_err = 1'b0;
`endif
  end

  // Next-state, request latch, and response data computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = op_err ? 32'h0 : (op_we ? op_merged : op_old);
    end
  end

  // Control and response registers; reset drops any pending request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store commits on the edge entering RESP, so a store cut off by reset never lands.
  always_ff @(posedge clk) begin
    if (enter_resp && op_we && !op_err) begin
      mem[op_idx] <= op_merged;
    end
  end

endmodule
